// File: rtl/iter_divider_pkg.sv
// Shared types and encodings for the iterative restoring divider:
// FSM state enum, fixup selector bits and result-flag bit positions.
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } div_state_e;

    // Fixup selector: which magnitudes get negated after the iterations.
    localparam int FIX_Q_BIT = 0;
    localparam int FIX_R_BIT = 1;
    localparam logic [1:0] FIX_NONE  = 2'b00;
    localparam logic [1:0] FIX_NEG_Q = 2'b01;
    localparam logic [1:0] FIX_NEG_R = 2'b10;

    // Result flag vector layout.
    localparam int FLAG_OVF_BIT = 0;
    localparam int FLAG_DBZ_BIT = 1;
    localparam logic [1:0] FLAGS_NONE = 2'b00;

    // Quotient sign follows sign(dividend) xor sign(divisor); remainder follows the dividend.
    function automatic logic [1:0] fixup_sel(input logic mode_signed,
                                             input logic dvd_neg,
                                             input logic dvs_neg);
        logic [1:0] sel;
        sel = FIX_NONE;
        if (mode_signed && (dvd_neg ^ dvs_neg)) sel = sel | FIX_NEG_Q;
        if (mode_signed && dvd_neg)             sel = sel | FIX_NEG_R;
        return sel;
    endfunction

endpackage

// File: rtl/iter_divider_if.sv
// Request/response bundle of the divider. Both sides use valid/ready:
// a transfer happens on a rising edge where valid and ready are both high.
interface iter_divider_if #(
    parameter int N     = 8,
    parameter int M     = 8,
    parameter int TAG_W = 4
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic             signed_i;
    logic [N-1:0]     dividend_i;
    logic [M-1:0]     divisor_i;
    logic [TAG_W-1:0] tag_i;

    logic             out_valid_o;
    logic             out_ready_i;
    logic [N-1:0]     quotient_o;
    logic [M-1:0]     remainder_o;
    logic [TAG_W-1:0] tag_o;
    logic             dbz_o;
    logic             ovf_o;

    modport slave (
        input  in_valid_i, signed_i, dividend_i, divisor_i, tag_i, out_ready_i,
        output in_ready_o, out_valid_o, quotient_o, remainder_o, tag_o, dbz_o, ovf_o
    );

    modport master (
        output in_valid_i, signed_i, dividend_i, divisor_i, tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, quotient_o, remainder_o, tag_o, dbz_o, ovf_o
    );
endinterface

// File: rtl/iter_divider_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor if it fits, and report the resulting quotient bit.
module div_step #(
    parameter int M = 8
) (
    input  logic [M:0]   rem_i,
    input  logic         bit_i,
    input  logic [M-1:0] divisor_i,
    output logic [M:0]   rem_o,
    output logic         q_bit_o
);
    logic [M+1:0] shifted;
    logic [M+1:0] dvs_ext;

    always_comb begin
        shifted = {rem_i, bit_i};
        dvs_ext = {2'b00, divisor_i};
        q_bit_o = (shifted >= dvs_ext);
        rem_o   = q_bit_o ? (M+1)'(shifted - dvs_ext) : shifted[M:0];
    end
endmodule

// File: rtl/iter_divider.sv
// Iterative signed/unsigned divider: one quotient bit per cycle on operand
// magnitudes, then a sign fixup cycle, then the result is held until taken.
module iter_divider
    import div_pkg::*;
#(
    parameter int N     = 8,
    parameter int M     = 8,
    parameter int TAG_W = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    iter_divider_if.slave bus,
    output div_state_e state_o
);
    localparam int CW = $clog2(N + 1);

    div_state_e state_q, state_d;
    logic accept, step_en, fix_en, complete;

    logic [CW-1:0]    cnt_q;
    logic [N-1:0]     work_q;
    logic [M:0]       rem_q;
    logic [M-1:0]     dvs_q;
    logic             mode_q, dvd_neg_q, dvs_neg_q, ovf_pend_q;
    logic [TAG_W-1:0] tag_hold_q;

    logic [N-1:0]     quot_q;
    logic [M-1:0]     rem_out_q;
    logic [TAG_W-1:0] tag_out_q;
    logic [1:0]       flags_q;

    logic             dvd_neg_in, dvs_neg_in, ovf_in;
    logic [N-1:0]     dvd_mag_in;
    logic [M-1:0]     dvs_mag_in;
    logic [M:0]       step_rem;
    logic             step_q_bit;
    logic [1:0]       fix;
    logic             dbz;
    logic [N-1:0]     quot_fix;
    logic [M-1:0]     rem_fix;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        step_en  = 1'b0;
        fix_en   = 1'b0;
        complete = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid_i) begin
                    accept  = 1'b1;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                step_en = 1'b1;
                if (cnt_q == CW'(N - 1)) state_d = ST_FIXUP;
            end
            ST_FIXUP: begin
                fix_en  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready_i) begin
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand capture: only magnitudes and sign bits are kept.
    always_comb begin
        dvd_neg_in = bus.signed_i & bus.dividend_i[N-1];
        dvs_neg_in = bus.signed_i & bus.divisor_i[M-1];
        dvd_mag_in = dvd_neg_in ? -bus.dividend_i : bus.dividend_i;
        dvs_mag_in = dvs_neg_in ? -bus.divisor_i  : bus.divisor_i;
        ovf_in     = bus.signed_i
                   & (bus.dividend_i == {1'b1, {(N-1){1'b0}}})
                   & (bus.divisor_i == {M{1'b1}});
    end

    div_step #(.M(M)) u_step (
        .rem_i     (rem_q),
        .bit_i     (work_q[N-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_q_bit)
    );

    // A zero divisor makes every step succeed with nothing subtracted, so the
    // partial remainder ends up holding the low dividend bits; the normal
    // remainder fixup then reproduces dividend[M-1:0] in either mode.
    always_comb begin
        fix      = fixup_sel(mode_q, dvd_neg_q, dvs_neg_q);
        dbz      = (dvs_q == '0);
        quot_fix = dbz ? {N{1'b1}} : (fix[FIX_Q_BIT] ? -work_q : work_q);
        rem_fix  = fix[FIX_R_BIT] ? -rem_q[M-1:0] : rem_q[M-1:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            work_q     <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            mode_q     <= 1'b0;
            dvd_neg_q  <= 1'b0;
            dvs_neg_q  <= 1'b0;
            ovf_pend_q <= 1'b0;
            tag_hold_q <= '0;
        end else if (accept) begin
            cnt_q      <= '0;
            work_q     <= dvd_mag_in;
            rem_q      <= '0;
            dvs_q      <= dvs_mag_in;
            mode_q     <= bus.signed_i;
            dvd_neg_q  <= dvd_neg_in;
            dvs_neg_q  <= dvs_neg_in;
            ovf_pend_q <= ovf_in;
            tag_hold_q <= bus.tag_i;
        end else if (step_en) begin
            // Dividend bits leave at the top while quotient bits enter at the bottom.
            cnt_q  <= cnt_q + 1'b1;
            work_q <= {work_q[N-2:0], step_q_bit};
            rem_q  <= step_rem;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            quot_q    <= '0;
            rem_out_q <= '0;
            tag_out_q <= '0;
            flags_q   <= FLAGS_NONE;
        end else if (fix_en) begin
            quot_q                <= quot_fix;
            rem_out_q             <= rem_fix;
            tag_out_q             <= tag_hold_q;
            flags_q[FLAG_DBZ_BIT] <= dbz;
            flags_q[FLAG_OVF_BIT] <= ovf_pend_q & ~dbz;
        end else if (complete) begin
            flags_q <= FLAGS_NONE;
        end
    end

    assign bus.in_ready_o  = (state_q == ST_IDLE);
    assign bus.out_valid_o = (state_q == ST_DONE);
    assign bus.quotient_o  = quot_q;
    assign bus.remainder_o = rem_out_q;
    assign bus.tag_o       = tag_out_q;
    assign bus.dbz_o       = flags_q[FLAG_DBZ_BIT];
    assign bus.ovf_o       = flags_q[FLAG_OVF_BIT];
    assign state_o         = state_q;

    a_flags_only_in_done: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q != ST_DONE) |-> (flags_q == FLAGS_NONE));
    a_cnt_bounded: assert property (@(posedge clk_i) disable iff (rst_i)
        cnt_q <= CW'(N));
endmodule

// File: tb/tb_iter_divider.sv
// Bench for iter_divider: fixed vector table, hand-written handshake/reset
// sequences, and random operations checked against an arithmetic model.
module tb_iter_divider;
    import div_pkg::*;

    localparam int N     = 8;
    localparam int M     = 8;
    localparam int TAG_W = 4;
    localparam int W     = N + M + TAG_W + 2;
    localparam int LAT   = N + 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    iter_divider_if #(.N(N), .M(M), .TAG_W(TAG_W)) bus ();
    div_state_e dbg_state;

    iter_divider #(.N(N), .M(M), .TAG_W(TAG_W)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .bus     (bus),
        .state_o (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];
    int acc_cyc, comp_cyc, rel_cyc;

    logic             nxt_s;
    logic [N-1:0]     nxt_a;
    logic [M-1:0]     nxt_b;
    logic [TAG_W-1:0] nxt_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer division (truncating toward zero) plus the two special cases.
    function automatic logic [W-1:0] model(input logic s, input logic [N-1:0] a,
                                           input logic [M-1:0] b, input logic [TAG_W-1:0] t);
        logic [N-1:0] q;
        logic [M-1:0] r;
        logic dbz, ovf;
        longint sa, sb, qq, rr;
        dbz = 1'b0;
        ovf = 1'b0;
        if (b == '0) begin
            q   = '1;
            r   = a[M-1:0];
            dbz = 1'b1;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            if (sa == -(longint'(1) <<< (N - 1)) && sb == -1) begin
                q   = {1'b1, {(N-1){1'b0}}};
                r   = '0;
                ovf = 1'b1;
            end else begin
                qq = sa / sb;
                rr = sa % sb;
                q  = qq[N-1:0];
                r  = rr[M-1:0];
            end
        end else begin
            q = a / N'(b);
            r = M'(a % N'(b));
        end
        return {q, r, t, dbz, ovf};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic start_op(input logic s, input logic [N-1:0] a, input logic [M-1:0] b,
                            input logic [TAG_W-1:0] t, input logic [W-1:0] e);
        bus.signed_i   = s;
        bus.dividend_i = a;
        bus.divisor_i  = b;
        bus.tag_i      = t;
        bus.in_valid_i = 1'b1;
        for (int i = 0; i < 60 && !bus.in_ready_o; i++) @(negedge clk);
        check("accept_ready", 32'(bus.in_ready_o), 32'd1);
        @(posedge clk);
        #1;
        acc_cyc        = cyc;
        bus.in_valid_i = 1'b0;
        // Inputs may change freely once the operation is taken.
        bus.signed_i   = 1'($urandom);
        bus.dividend_i = N'($urandom);
        bus.divisor_i  = M'($urandom);
        bus.tag_i      = TAG_W'($urandom);
        exp_q.push_back(e);
    endtask

    task automatic cmp_outputs(input logic [W-1:0] e, input string name);
        check({name, "_valid"}, 32'(bus.out_valid_o), 32'd1);
        check({name, "_q"},     32'(bus.quotient_o),  32'(e[W-1 -: N]));
        check({name, "_r"},     32'(bus.remainder_o), 32'(e[W-N-1 -: M]));
        check({name, "_tag"},   32'(bus.tag_o),       32'(e[TAG_W+1:2]));
        check({name, "_dbz"},   32'(bus.dbz_o),       32'(e[1]));
        check({name, "_ovf"},   32'(bus.ovf_o),       32'(e[0]));
    endtask

    // Latency is the number of edges from the accepting edge to the first
    // edge that could complete the result (out_valid_o seen high before it).
    task automatic finish_op(input int stall, input logic chain, input string name);
        logic [W-1:0] e;
        e = exp_q.pop_front();
        @(negedge clk);
        while (!bus.out_valid_o && (cyc - acc_cyc) < 40) @(negedge clk);
        check({name, "_latency"}, 32'(cyc - acc_cyc + 1), 32'(LAT));
        for (int k = 0; k < stall; k++) begin
            cmp_outputs(e, {name, "_hold"});
            check({name, "_hold_in_ready"}, 32'(bus.in_ready_o), 32'd0);
            @(negedge clk);
        end
        cmp_outputs(e, name);
        check({name, "_done_in_ready"}, 32'(bus.in_ready_o), 32'd0);
        bus.out_ready_i = 1'b1;
        if (chain) begin
            bus.signed_i   = nxt_s;
            bus.dividend_i = nxt_a;
            bus.divisor_i  = nxt_b;
            bus.tag_i      = nxt_t;
            bus.in_valid_i = 1'b1;
        end
        @(posedge clk);
        #1;
        comp_cyc        = cyc;
        bus.out_ready_i = 1'b0;
        check({name, "_post_valid"}, 32'(bus.out_valid_o), 32'd0);
        check({name, "_post_flags"}, 32'({bus.dbz_o, bus.ovf_o}), 32'd0);
        check({name, "_post_ready"}, 32'(bus.in_ready_o), 32'd1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic             s;
        logic [N-1:0]     a;
        logic [M-1:0]     b;
        logic [TAG_W-1:0] t;
        logic [N-1:0]     q;
        logic [M-1:0]     r;
        logic             dbz;
        logic             ovf;
        int               stall;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic             r_s;
        logic [N-1:0]     r_a;
        logic [M-1:0]     r_b;
        logic [TAG_W-1:0] r_t;
        int               sel;

        //         s     a      b      t     q      r      dbz   ovf  stall
        vecs[0]  = '{1'b1, 8'hF9, 8'h02, 4'h3, 8'hFD, 8'hFF, 1'b0, 1'b0, 0};
        vecs[1]  = '{1'b0, 8'hC8, 8'h07, 4'h1, 8'h1C, 8'h04, 1'b0, 1'b0, 1};
        vecs[2]  = '{1'b1, 8'hC8, 8'h07, 4'h2, 8'hF8, 8'h00, 1'b0, 1'b0, 0};
        vecs[3]  = '{1'b0, 8'hC8, 8'h00, 4'h4, 8'hFF, 8'hC8, 1'b1, 1'b0, 2};
        vecs[4]  = '{1'b1, 8'h80, 8'hFF, 4'h5, 8'h80, 8'h00, 1'b0, 1'b1, 0};
        vecs[5]  = '{1'b1, 8'h80, 8'h01, 4'h6, 8'h80, 8'h00, 1'b0, 1'b0, 0};
        vecs[6]  = '{1'b1, 8'h07, 8'hFE, 4'h7, 8'hFD, 8'h01, 1'b0, 1'b0, 5};
        vecs[7]  = '{1'b0, 8'hFF, 8'hFF, 4'h8, 8'h01, 8'h00, 1'b0, 1'b0, 0};
        vecs[8]  = '{1'b1, 8'h05, 8'hFF, 4'h9, 8'hFB, 8'h00, 1'b0, 1'b0, 0};
        vecs[9]  = '{1'b1, 8'h80, 8'h00, 4'hA, 8'hFF, 8'h80, 1'b1, 1'b0, 1};
        vecs[10] = '{1'b0, 8'h00, 8'h05, 4'hB, 8'h00, 8'h00, 1'b0, 1'b0, 0};
        vecs[11] = '{1'b1, 8'hF9, 8'hF9, 4'hC, 8'h01, 8'h00, 1'b0, 1'b0, 0};

        rst             = 1'b1;
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;
        bus.signed_i    = 1'b0;
        bus.dividend_i  = '0;
        bus.divisor_i   = '0;
        bus.tag_i       = '0;
        repeat (3) @(negedge clk);
        check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
        check("reset_out_valid", 32'(bus.out_valid_o), 32'd0);
        rst     = 1'b0;
        rel_cyc = cyc;
        check("reset_in_ready", 32'(bus.in_ready_o), 32'd1);
        check("reset_outputs", 32'({bus.quotient_o, bus.remainder_o, bus.tag_o, bus.dbz_o, bus.ovf_o}), 32'd0);

        // Table vectors; the first one also checks acceptance right after reset release.
        for (int i = 0; i < 12; i++) begin
            start_op(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].t,
                     {vecs[i].q, vecs[i].r, vecs[i].t, vecs[i].dbz, vecs[i].ovf});
            if (i == 0) check("first_accept_delay", 32'(acc_cyc - rel_cyc), 32'd1);
            finish_op(vecs[i].stall, 1'b0, $sformatf("vec%0d", i));
        end

        // Back-to-back: next request waits through the completion edge.
        nxt_s = 1'b1; nxt_a = 8'h9C; nxt_b = 8'h03; nxt_t = 4'hE;
        start_op(1'b0, 8'd100, 8'd3, 4'hD, {8'd33, 8'd1, 4'hD, 1'b0, 1'b0});
        finish_op(2, 1'b1, "chain_a");
        start_op(nxt_s, nxt_a, nxt_b, nxt_t, {8'hDF, 8'hFF, 4'hE, 1'b0, 1'b0});
        check("chain_accept_delay", 32'(acc_cyc - comp_cyc), 32'd1);
        finish_op(0, 1'b0, "chain_b");

        // Reset in the middle of the iterations discards the operation.
        start_op(1'b1, 8'h64, 8'h07, 4'h5, model(1'b1, 8'h64, 8'h07, 4'h5));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        void'(exp_q.pop_back());
        check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("midrst_out_valid", 32'(bus.out_valid_o), 32'd0);
        check("midrst_outputs", 32'({bus.quotient_o, bus.remainder_o, bus.tag_o, bus.dbz_o, bus.ovf_o}), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("midrst_hold_valid", 32'(bus.out_valid_o), 32'd0);
        end
        rst     = 1'b0;
        rel_cyc = cyc;
        start_op(1'b1, 8'hE2, 8'h04, 4'h9, model(1'b1, 8'hE2, 8'h04, 4'h9));
        check("postrst_accept_delay", 32'(acc_cyc - rel_cyc), 32'd1);
        finish_op(0, 1'b0, "postrst");

        // Random operations against the model.
        for (int i = 0; i < 40; i++) begin
            r_s = 1'($urandom_range(0, 1));
            r_a = N'($urandom);
            sel = $urandom_range(0, 9);
            case (sel)
                0:       r_b = '0;
                1:       r_b = '1;
                2:       r_b = M'(1);
                default: r_b = M'($urandom);
            endcase
            if ($urandom_range(0, 7) == 0) r_a = {1'b1, {(N-1){1'b0}}};
            r_t = TAG_W'($urandom);
            start_op(r_s, r_a, r_b, r_t, model(r_s, r_a, r_b, r_t));
            finish_op($urandom_range(0, 2), 1'b0, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
